// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel line-buffer sequencer.
// The state enum is shared so the sequencer and any future observers agree on encoding.
package sobel_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        FILL    = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int DEF_H_ACT    = 1280;
    localparam int DEF_V_ACT    = 720;
    localparam int DEF_CNT_W    = 12;
    localparam int DEF_PIPE_LAT = 2;

    // {hs, vs, de, win_valid} travel together through the alignment delay
    localparam int DLY_W = 4;

endpackage

// File: rtl/sobel_sync_dly.sv
// Reset-to-zero shift register of configurable depth and width.
// Keeps the video timing aligned with the window/gradient pipeline latency.
module sobel_sync_dly
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT,
    parameter int WIDTH = DLY_W
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_d
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // shift one stage per pixel clock, clearing every stage on reset
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_d = r_pipe[DEPTH-1];

endmodule

// File: rtl/sobel_linebuf_ctrl.sv
// Sequencer for the 3-line Sobel window: tracks pixel position from hs/vs/de,
// drives the two line FIFOs, aligns timing to the gradient output and flags bad frames.
module sobel_linebuf_ctrl
    import sobel_pkg::*;
#(
    parameter int H_ACT    = DEF_H_ACT,
    parameter int V_ACT    = DEF_V_ACT,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic             i_de,
    output logic             fifo_rst,
    output logic             fifo1_wr_en,
    output logic             fifo1_rd_en,
    output logic             fifo2_wr_en,
    output logic             fifo2_rd_en,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic             o_win_valid,
    output logic             err_len,
    output logic             err_lines,
    output logic [15:0]      frame_cnt
);

    localparam logic [CNT_W-1:0] LP_H_MAX = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] LP_V_MAX = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_TWO   = CNT_W'(2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_vs_q;
    logic             r_de_q;
    logic             r_fifo_rst;
    logic             r_x_ovf;
    logic             r_err_len;
    logic             r_err_lines;
    logic [CNT_W-1:0] r_x_cnt;
    logic [CNT_W-1:0] r_y_cnt;
    logic [15:0]      r_frame_cnt;

    logic             w_active;
    logic             w_vs_rise;
    logic             w_de_acc;
    logic             w_line_end;
    logic             w_y_ge1;
    logic             w_y_ge2;
    logic             w_x_ge2;
    logic             w_f1_wr;
    logic             w_f1_rd;
    logic             w_f2_rd;
    logic             w_win_pre;
    logic [DLY_W-1:0] w_dly_out;

    // a de cycle only counts once a frame has started, outside vsync and reset
    assign w_active   = (r_state != WAIT_VS);
    assign w_vs_rise  = i_vs & ~r_vs_q;
    assign w_de_acc   = i_de & w_active & ~i_vs & ~rst;
    assign w_line_end = r_de_q & ~w_de_acc;
    assign w_y_ge1    = (r_y_cnt >= LP_ONE);
    assign w_y_ge2    = (r_y_cnt >= LP_TWO);
    assign w_x_ge2    = (r_x_cnt >= LP_TWO);

    // state register
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_state <= WAIT_VS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state plus zero-latency FIFO strobes and pre-delay window qualifier
    always_comb begin
        w_state_nxt = r_state;
        w_f1_wr     = 1'b0;
        w_f1_rd     = 1'b0;
        w_f2_rd     = 1'b0;
        w_win_pre   = 1'b0;
        if (w_vs_rise) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                WAIT_VS: begin
                    w_state_nxt = WAIT_VS;
                end
                FILL: begin
                    w_f1_wr = w_de_acc;
                    w_f1_rd = w_de_acc & w_y_ge1;
                    // the line that brings y_cnt to 2 completes the fill
                    if (w_line_end && w_y_ge1) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
                RUN: begin
                    w_f1_wr     = w_de_acc;
                    w_f1_rd     = w_de_acc & w_y_ge1;
                    w_f2_rd     = w_de_acc & w_y_ge2;
                    w_win_pre   = w_de_acc & w_y_ge2 & w_x_ge2;
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = WAIT_VS;
                end
            endcase
        end
    end

    // edge-detect history and the registered FIFO clear request
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_vs_q     <= 1'b0;
            r_de_q     <= 1'b0;
            r_fifo_rst <= 1'b1;
        end else begin
            r_vs_q     <= i_vs;
            r_de_q     <= w_de_acc;
            r_fifo_rst <= i_vs;
        end
    end

    // position counters, sticky frame errors and the completed-frame count
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_x_ovf     <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_lines <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else if (w_vs_rise) begin
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_x_ovf     <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_lines <= 1'b0;
            if (w_active) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end else if (w_de_acc) begin
            // x_cnt saturates, so remember overlong lines separately
            if (r_x_cnt == LP_H_MAX) begin
                r_x_ovf <= 1'b1;
            end else begin
                r_x_cnt <= r_x_cnt + LP_ONE;
            end
        end else if (w_line_end) begin
            r_x_cnt <= '0;
            r_x_ovf <= 1'b0;
            if ((r_x_cnt != LP_H_MAX) || r_x_ovf) begin
                r_err_len <= 1'b1;
            end else begin
                r_err_len <= r_err_len;
            end
            if (r_y_cnt == LP_V_MAX) begin
                r_err_lines <= 1'b1;
            end else begin
                r_y_cnt <= r_y_cnt + LP_ONE;
            end
        end else begin
            r_x_cnt <= r_x_cnt;
        end
    end

    sobel_sync_dly #(
        .DEPTH (PIPE_LAT),
        .WIDTH (DLY_W)
    ) u_sync_dly (
        .pix_clk (pix_clk),
        .rst     (rst),
        .i_d     ({i_hs, i_vs, i_de, w_win_pre}),
        .o_d     (w_dly_out)
    );

    // rst is folded in so the FIFOs are held clear during reset and one cycle after
    assign fifo_rst    = rst | r_fifo_rst;
    assign fifo1_wr_en = w_f1_wr;
    assign fifo1_rd_en = w_f1_rd;
    assign fifo2_wr_en = w_f1_rd;
    assign fifo2_rd_en = w_f2_rd;
    assign x_cnt       = r_x_cnt;
    assign y_cnt       = r_y_cnt;
    assign err_len     = r_err_len;
    assign err_lines   = r_err_lines;
    assign frame_cnt   = r_frame_cnt;
    assign {o_hs, o_vs, o_de, o_win_valid} = w_dly_out;

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
// Self-checking bench for sobel_linebuf_ctrl: a frame/line level reference model,
// a hand-derived vector table, scripted corner cases and randomized timing.
module tb_sobel_linebuf_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 12;
    localparam int PL = 2;

    logic          pix_clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_hs = 1'b0;
    logic          i_vs = 1'b0;
    logic          i_de = 1'b0;
    logic          fifo_rst, fifo1_wr_en, fifo1_rd_en, fifo2_wr_en, fifo2_rd_en;
    logic [CW-1:0] x_cnt, y_cnt;
    logic          o_hs, o_vs, o_de, o_win_valid, err_len, err_lines;
    logic [15:0]   frame_cnt;

    sobel_linebuf_ctrl #(.H_ACT(H), .V_ACT(V), .CNT_W(CW), .PIPE_LAT(PL)) dut (
        .pix_clk(pix_clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
        .fifo_rst(fifo_rst), .fifo1_wr_en(fifo1_wr_en), .fifo1_rd_en(fifo1_rd_en),
        .fifo2_wr_en(fifo2_wr_en), .fifo2_rd_en(fifo2_rd_en),
        .x_cnt(x_cnt), .y_cnt(y_cnt), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
        .o_win_valid(o_win_valid), .err_len(err_len), .err_lines(err_lines),
        .frame_cnt(frame_cnt)
    );

    always #5 pix_clk = ~pix_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: frame started?, true de run length, lines completed in frame
    bit         m_started, m_prev_vs, m_prev_acc, m_frst_q, m_err_len;
    int         m_len, m_lines, m_frame;
    logic [3:0] m_dq[$];

    // values seen at the latest sample point, and per-scenario pulse tallies
    logic       s_frst, s_f1wr, s_f1rd, s_f2wr, s_f2rd, s_err_len, s_err_lines;
    int         s_x, s_y, s_frame;
    int         t_f1wr, t_f1rd, t_f2wr, t_f2rd, t_win;

    typedef struct {
        logic r, v, d;
        logic e_frst, e_f1wr, e_f1rd, e_f2rd;
        int   e_x, e_y, e_frame;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, h, v, d, acc, win);
        if (r) begin
            m_started = 1'b0; m_prev_vs = 1'b0; m_prev_acc = 1'b0; m_frst_q = 1'b1;
            m_err_len = 1'b0; m_len = 0; m_lines = 0; m_frame = 0;
            m_dq.delete();
            for (int i = 0; i < PL; i++) m_dq.push_back(4'b0000);
        end else begin
            m_dq.push_back({h, v, d, win});
            void'(m_dq.pop_front());
            m_frst_q = v;
            if (v && !m_prev_vs) begin
                if (m_started) m_frame = (m_frame + 1) % 65536;
                m_started = 1'b1; m_len = 0; m_lines = 0; m_err_len = 1'b0;
            end else if (acc) begin
                m_len++;
            end else if (m_prev_acc) begin
                if (m_len != H) m_err_len = 1'b1;
                m_lines++;
                m_len = 0;
            end
            m_prev_vs  = v;
            m_prev_acc = acc;
        end
    endtask

    // drive one cycle, compare every output against the model at the falling edge
    task automatic step(input logic r, h, v, d);
        logic acc, win;
        logic [3:0] dly;
        rst = r; i_hs = h; i_vs = v; i_de = d;
        @(negedge pix_clk);
        acc = d && m_started && !v && !r;
        win = acc && (m_lines >= 2) && (m_len >= 2);
        dly = m_dq[0];
        chk("fifo_rst",    32'(fifo_rst),    32'(r | m_frst_q));
        chk("fifo1_wr_en", 32'(fifo1_wr_en), 32'(acc));
        chk("fifo1_rd_en", 32'(fifo1_rd_en), 32'(acc && m_lines >= 1));
        chk("fifo2_wr_en", 32'(fifo2_wr_en), 32'(acc && m_lines >= 1));
        chk("fifo2_rd_en", 32'(fifo2_rd_en), 32'(acc && m_lines >= 2));
        chk("x_cnt",       32'(x_cnt),       (m_len > H) ? H : m_len);
        chk("y_cnt",       32'(y_cnt),       (m_lines > V) ? V : m_lines);
        chk("err_len",     32'(err_len),     32'(m_err_len));
        chk("err_lines",   32'(err_lines),   32'(m_lines > V));
        chk("frame_cnt",   32'(frame_cnt),   m_frame);
        chk("o_hs",        32'(o_hs),        32'(dly[3]));
        chk("o_vs",        32'(o_vs),        32'(dly[2]));
        chk("o_de",        32'(o_de),        32'(dly[1]));
        chk("o_win_valid", 32'(o_win_valid), 32'(dly[0]));
        s_frst = fifo_rst; s_f1wr = fifo1_wr_en; s_f1rd = fifo1_rd_en;
        s_f2wr = fifo2_wr_en; s_f2rd = fifo2_rd_en; s_err_len = err_len;
        s_err_lines = err_lines; s_x = int'(x_cnt); s_y = int'(y_cnt); s_frame = int'(frame_cnt);
        if (fifo1_wr_en) t_f1wr++;
        if (fifo1_rd_en) t_f1rd++;
        if (fifo2_wr_en) t_f2wr++;
        if (fifo2_rd_en) t_f2rd++;
        if (o_win_valid) t_win++;
        model_update(r, h, v, d, acc, win);
        @(posedge pix_clk);
        #1;
    endtask

    task automatic line(input int n, input int gap);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < gap; i++) step(1'b0, (i == 0), 1'b0, 1'b0);
    endtask

    task automatic vsync();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_tally();
        t_f1wr = 0; t_f1rd = 0; t_f2wr = 0; t_f2rd = 0; t_win = 0;
    endtask

    // one clean frame of V lines of H pixels, then the pulse totals it must produce
    task automatic full_frame(input string tag);
        vsync();
        clear_tally();
        for (int l = 0; l < V; l++) line(H, 3);
        chk({tag, "_f1wr_total"}, t_f1wr, 32);
        chk({tag, "_f1rd_total"}, t_f1rd, 24);
        chk({tag, "_f2wr_total"}, t_f2wr, 24);
        chk({tag, "_f2rd_total"}, t_f2rd, 16);
        chk({tag, "_win_total"},  t_win,  12);
    endtask

    initial begin
        //            r     v     d     frst  f1wr  f1rd  f2rd  x  y  frame
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0};

        @(posedge pix_clk);
        #1;
        model_update(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_tally();

        // reset, de before any vsync, vsync rising together with de, start of first line
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, 1'b0, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_fifo_rst", i), 32'(s_frst), 32'(tbl[i].e_frst));
            chk($sformatf("tbl%0d_f1wr", i),     32'(s_f1wr), 32'(tbl[i].e_f1wr));
            chk($sformatf("tbl%0d_f1rd", i),     32'(s_f1rd), 32'(tbl[i].e_f1rd));
            chk($sformatf("tbl%0d_f2rd", i),     32'(s_f2rd), 32'(tbl[i].e_f2rd));
            chk($sformatf("tbl%0d_x", i),        s_x,         tbl[i].e_x);
            chk($sformatf("tbl%0d_y", i),        s_y,         tbl[i].e_y);
            chk($sformatf("tbl%0d_frame", i),    s_frame,     tbl[i].e_frame);
        end
        line(5, 3);

        full_frame("frame_a");

        // short line sets err_len, held until the next vsync clears it
        vsync();
        line(H, 3);
        line(H - 1, 3);
        chk("short_line_err_len", 32'(s_err_len), 32'd1);
        line(H, 3);
        chk("err_len_held", 32'(s_err_len), 32'd1);
        vsync();
        chk("err_len_cleared", 32'(s_err_len), 32'd0);

        // one line too many sets err_lines while y_cnt holds at V
        for (int l = 0; l < V + 1; l++) line(H, 3);
        chk("extra_line_err_lines", 32'(s_err_lines), 32'd1);
        chk("extra_line_y_hold", s_y, V);
        chk("extra_line_err_len", 32'(s_err_len), 32'd0);

        // reset in the middle of line 2
        vsync();
        line(H, 3);
        line(H, 3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_cycle_fifo_rst", 32'(s_frst), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("after_rst_fifo_rst", 32'(s_frst), 32'd1);
        chk("after_rst_f1wr", 32'(s_f1wr), 32'd0);
        chk("after_rst_f1rd", 32'(s_f1rd), 32'd0);
        chk("after_rst_f2rd", 32'(s_f2rd), 32'd0);
        chk("after_rst_x", s_x, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("after_rst2_fifo_rst", 32'(s_frst), 32'd0);
        chk("after_rst2_f1wr", 32'(s_f1wr), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        full_frame("frame_b");

        // vsync rise coinciding with de, then three complete frames
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("vs_de_f1wr", 32'(s_f1wr), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("vs_de_x", s_x, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("vs_de_x_after", s_x, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < V; l++) line(H, 3);
            vsync();
        end
        chk("three_frames", s_frame, 3);

        // randomized timing: odd line lengths, stray vsync, vsync mid-line, resets
        for (int k = 0; k < 250; k++) begin
            int sel;
            sel = int'($urandom_range(0, 39));
            if (sel == 0) begin
                step(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            end else if (sel < 3) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                    step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
                step(1'b0, 1'b0, 1'b0, 1'b0);
            end else if (sel == 3) begin
                for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
                step(1'b0, 1'b0, 1'b1, 1'b1);
                step(1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                line(int'($urandom_range(H - 2, H + 2)), int'($urandom_range(1, 4)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
